// File: rtl/muldiv_seq_pkg.sv
// Shared constants and types for the sequential multiply/divide unit.
// Op encodings, ALU control codes and the controller state enum.
package muldiv_seq_pkg;

  localparam int WIDTH = 32;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/muldiv_seq_alu.sv
// Add/subtract ALU shared by the multiply and divide iterations.
// Pure combinational; control selects the operation.
module muldiv_seq_alu
  import muldiv_seq_pkg::*;
(
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       ctrl_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    unique case (ctrl_i)
      ALU_SUB: y_o = a_i - b_i;
      default: y_o = a_i + b_i;
    endcase
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential 32-bit unsigned shift-add multiplier / restoring divider.
// One iteration per cycle, 32 iterations, all arithmetic via one ALU.
module muldiv_seq #(
  parameter int WIDTH = muldiv_seq_pkg::WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic             Op,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ResultLo,
  output logic [WIDTH-1:0] ResultHi,
  output logic             DivByZero
);
  import muldiv_seq_pkg::*;

  state_e           state_q;
  logic             op_q;
  logic [4:0]       cnt_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_lo_q;
  logic [WIDTH-1:0] res_hi_q;
  logic             dbz_q;

  logic [WIDTH-1:0] hi_d;
  logic [WIDTH-1:0] lo_d;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_y;
  logic [WIDTH-1:0] rem_sh;
  logic [WIDTH-1:0] sum;
  logic [2:0]       alu_ctrl;
  logic             div_run;
  logic             carry;
  logic             ge;

  assign div_run  = (state_q == RUN) && (op_q == OP_DIV);
  assign alu_ctrl = div_run ? ALU_SUB : ALU_ADD;
  assign rem_sh   = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
  assign alu_a    = div_run ? rem_sh : hi_q;

  muldiv_seq_alu u_alu (
    .a_i   (alu_a),
    .b_i   (b_q),
    .ctrl_i(alu_ctrl),
    .y_o   (alu_y)
  );

  // hi holds Acc/Rem, lo holds multiplier/quotient, b holds mcand/divisor
  always_comb begin
    sum   = hi_q;
    carry = 1'b0;
    ge    = 1'b0;
    hi_d  = hi_q;
    lo_d  = lo_q;
    unique case (1'b1)
      (op_q == OP_DIV): begin
        ge   = hi_q[WIDTH-1] | (rem_sh >= b_q);
        hi_d = ge ? alu_y : rem_sh;
        lo_d = {lo_q[WIDTH-2:0], ge};
      end
      default: begin
        sum   = lo_q[0] ? alu_y : hi_q;
        carry = lo_q[0] & (alu_y < b_q);
        hi_d  = {carry, sum[WIDTH-1:1]};
        lo_d  = {sum[0], lo_q[WIDTH-1:1]};
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      op_q     <= OP_MUL;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          if (Start) begin
            op_q  <= Op;
            cnt_q <= '0;
            dbz_q <= 1'b0;
            hi_q  <= '0;
            lo_q  <= (Op == OP_DIV) ? OpA : OpB;
            b_q   <= (Op == OP_DIV) ? OpB : OpA;
            if (Op == OP_DIV && OpB == '0) begin
              state_q  <= DONE;
              res_lo_q <= '1;
              res_hi_q <= OpA;
              dbz_q    <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q  <= DONE;
            res_lo_q <= lo_d;
            res_hi_q <= hi_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Busy      = (state_q == RUN);
  assign Done      = (state_q == DONE);
  assign ResultLo  = res_lo_q;
  assign ResultHi  = res_hi_q;
  assign DivByZero = dbz_q;

endmodule
